// File: rtl/vga_scanout.sv
// VGA read-side scanout: raster counters, framebuffer read addressing and a
// pix_ce-gated alignment pipeline so sync, de and colour reach the pins together.
module vga_scanout #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   RD_LAT   = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    output logic [9:0] fb_x,
    output logic [9:0] fb_y,
    output logic       fb_r_en,
    input  logic [7:0] fb_data,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic       de,
    output logic       frame_start
);

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]        h_cnt_q, h_cnt_d;
    logic [9:0]        v_cnt_q, v_cnt_d;
    logic [RD_LAT-1:0] act_pipe_q, act_pipe_d;
    logic [RD_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [RD_LAT-1:0] vs_pipe_q, vs_pipe_d;

    logic              active;
    logic              hs_raw;
    logic              vs_raw;
    logic [RD_LAT:0]   act_chain;
    logic [RD_LAT:0]   hs_chain;
    logic [RD_LAT:0]   vs_chain;

    // Raster position decode at the counter (address) side of the pipeline.
    always_comb begin
        active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_raw = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_raw = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Current decode enters at bit 0; dropping the top bit shifts every stage by one.
    always_comb begin
        act_chain = {act_pipe_q, active};
        hs_chain  = {hs_pipe_q, hs_raw};
        vs_chain  = {vs_pipe_q, vs_raw};
    end

    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        act_pipe_d = act_pipe_q;
        hs_pipe_d  = hs_pipe_q;
        vs_pipe_d  = vs_pipe_q;
        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            act_pipe_d = act_chain[RD_LAT-1:0];
            hs_pipe_d  = hs_chain[RD_LAT-1:0];
            vs_pipe_d  = vs_chain[RD_LAT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt_q    <= 10'd0;
            v_cnt_q    <= 10'd0;
            act_pipe_q <= '0;
            hs_pipe_q  <= {RD_LAT{~SYNC_POL}};
            vs_pipe_q  <= {RD_LAT{~SYNC_POL}};
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            act_pipe_q <= act_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
        end
    end

    // The read port holds its data between ticks, so colour is muxed straight
    // from fb_data under the delayed active bit.
    always_comb begin
        fb_x        = active ? h_cnt_q : 10'd0;
        fb_y        = active ? v_cnt_q : 10'd0;
        fb_r_en     = active;
        frame_start = rst && pix_ce && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        de          = act_pipe_q[RD_LAT-1];
        hsync       = hs_pipe_q[RD_LAT-1];
        vsync       = vs_pipe_q[RD_LAT-1];
        rgb         = de ? fb_data : 8'h00;
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size RD_LAT=1 instance and a shrunken RD_LAT=3,
// active-high-sync instance, both checked every cycle against a raster model.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic pix_ce;

  logic [9:0] fb_x_a, fb_y_a, fb_x_b, fb_y_b;
  logic       fb_r_en_a, fb_r_en_b;
  logic [7:0] fb_data_a, fb_data_b;
  logic       hsync_a, vsync_a, de_a, frame_start_a;
  logic       hsync_b, vsync_b, de_b, frame_start_b;
  logic [7:0] rgb_a, rgb_b;

  vga_scanout #(.RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .fb_x(fb_x_a), .fb_y(fb_y_a), .fb_r_en(fb_r_en_a), .fb_data(fb_data_a),
    .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a), .de(de_a), .frame_start(frame_start_a)
  );

  vga_scanout #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .RD_LAT(3), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .fb_x(fb_x_b), .fb_y(fb_y_b), .fb_r_en(fb_r_en_b), .fb_data(fb_data_b),
    .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b), .de(de_b), .frame_start(frame_start_b)
  );

  // Timing of the two instances, index 0 = u_a, 1 = u_b.
  localparam int   HA [2] = '{640, 20};
  localparam int   HF [2] = '{16, 3};
  localparam int   HS [2] = '{96, 4};
  localparam int   HB [2] = '{48, 5};
  localparam int   VA [2] = '{480, 6};
  localparam int   VF [2] = '{10, 2};
  localparam int   VS [2] = '{2, 2};
  localparam int   VB [2] = '{33, 3};
  localparam int   LAT[2] = '{1, 3};
  localparam logic POL[2] = '{1'b0, 1'b1};

  function automatic logic [7:0] pix_f(input int x, input int y);
    return 8'((x * 3 + y * 5 + 90) & 255);
  endfunction

  // Framebuffer read ports: pixel for the presented address, RD_LAT ticks later.
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  always @(posedge clk) begin
    if (pix_ce) begin
      for (int j = 3; j > 0; j--) begin
        mem_a[j] <= mem_a[j-1];
        mem_b[j] <= mem_b[j-1];
      end
      mem_a[0] <= pix_f(int'(fb_x_a), int'(fb_y_a));
      mem_b[0] <= pix_f(int'(fb_x_b), int'(fb_y_b));
    end
  end
  assign fb_data_a = mem_a[LAT[0]-1];
  assign fb_data_b = mem_b[LAT[1]-1];

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic [7:0] pix;
  } ent_t;

  int   mh [2];
  int   mv [2];
  ent_t dl [2][4];

  function automatic ent_t cur_ent(input int i);
    ent_t e;
    e.act = (mh[i] < HA[i]) && (mv[i] < VA[i]);
    e.hs  = (mh[i] >= HA[i] + HF[i] && mh[i] < HA[i] + HF[i] + HS[i]) ? POL[i] : ~POL[i];
    e.vs  = (mv[i] >= VA[i] + VF[i] && mv[i] < VA[i] + VF[i] + VS[i]) ? POL[i] : ~POL[i];
    e.pix = e.act ? pix_f(mh[i], mv[i]) : 8'h00;
    return e;
  endfunction

  task automatic model_step(input int i);
    ent_t e;
    if (!rst) begin
      mh[i] = 0;
      mv[i] = 0;
      for (int j = 0; j < 4; j++) dl[i][j] = '{1'b0, ~POL[i], ~POL[i], 8'h00};
    end else if (pix_ce) begin
      e = cur_ent(i);
      for (int j = 3; j > 0; j--) dl[i][j] = dl[i][j-1];
      dl[i][0] = e;
      mh[i]++;
      if (mh[i] == HA[i] + HF[i] + HS[i] + HB[i]) begin
        mh[i] = 0;
        mv[i]++;
        if (mv[i] == VA[i] + VF[i] + VS[i] + VB[i]) mv[i] = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_inst(input int i, input logic [9:0] x, input logic [9:0] y,
                            input logic ren, input logic fs, input logic hs,
                            input logic vs, input logic d, input logic [7:0] c);
    ent_t cur;
    ent_t outp;
    string p;
    p    = (i == 0) ? "a" : "b";
    cur  = cur_ent(i);
    outp = dl[i][LAT[i]-1];
    chk({p, ".fb_x"}, 32'(x), cur.act ? 32'(mh[i]) : 32'd0);
    chk({p, ".fb_y"}, 32'(y), cur.act ? 32'(mv[i]) : 32'd0);
    chk({p, ".fb_r_en"}, 32'(ren), 32'(cur.act));
    chk({p, ".frame_start"}, 32'(fs), 32'(rst && pix_ce && mh[i] == 0 && mv[i] == 0));
    chk({p, ".hsync"}, 32'(hs), 32'(outp.hs));
    chk({p, ".vsync"}, 32'(vs), 32'(outp.vs));
    chk({p, ".de"}, 32'(d), 32'(outp.act));
    chk({p, ".rgb"}, 32'(c), 32'(outp.pix));
  endtask

  logic check_en = 1'b0;

  task automatic run_cycle(input logic r, input logic ce);
    @(negedge clk);
    rst    = r;
    pix_ce = ce;
    #1;
    if (check_en) begin
      check_inst(0, fb_x_a, fb_y_a, fb_r_en_a, frame_start_a, hsync_a, vsync_a, de_a, rgb_a);
      check_inst(1, fb_x_b, fb_y_b, fb_r_en_b, frame_start_b, hsync_b, vsync_b, de_b, rgb_b);
    end
    model_step(0);
    model_step(1);
    check_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fall0, fall1, low_a, de_cnt_a, de_first_a, fs_cnt_a;
    int hs_first_b, de_first_b, de_cnt_b, vs_cnt_b, vs_first_b, fs_cnt_b;
    int hs_half_b;
    logic prev_hs_a;
    int rst_left;

    rst    = 1'b0;
    pix_ce = 1'b0;

    // Constant pix_ce from reset release: timing landmarks after release.
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b1);
    fall0 = -1; fall1 = -1; low_a = 0; de_cnt_a = 0; de_first_a = -1; fs_cnt_a = 0;
    hs_first_b = -1; de_first_b = -1; de_cnt_b = 0; vs_cnt_b = 0; vs_first_b = -1; fs_cnt_b = 0;
    prev_hs_a = 1'b1;
    for (int idx = 0; idx < 1700; idx++) begin
      run_cycle(1'b1, 1'b1);
      if (prev_hs_a && !hsync_a) begin
        if (fall0 < 0) fall0 = idx;
        else if (fall1 < 0) fall1 = idx;
      end
      prev_hs_a = hsync_a;
      if (idx < 800 && !hsync_a) low_a++;
      if (idx < 800 && de_a) de_cnt_a++;
      if (de_a && de_first_a < 0) de_first_a = idx;
      if (frame_start_a) fs_cnt_a++;
      if (hsync_b && hs_first_b < 0) hs_first_b = idx;
      if (de_b && de_first_b < 0) de_first_b = idx;
      if (idx < 416 && de_b) de_cnt_b++;
      if (idx < 416 && vsync_b) vs_cnt_b++;
      if (vsync_b && vs_first_b < 0) vs_first_b = idx;
      if (frame_start_b) fs_cnt_b++;
      if (idx == 0) begin
        chk("lit.a.origin_x", 32'(fb_x_a), 32'd0);
        chk("lit.a.origin_y", 32'(fb_y_a), 32'd0);
        chk("lit.a.origin_fs", 32'(frame_start_a), 32'd1);
      end
      if (idx == 1)   chk("lit.a.rgb_first", 32'(rgb_a), 32'h5a);
      if (idx == 640) chk("lit.a.rgb_last", 32'(rgb_a), 32'd215);
      if (idx == 700) chk("lit.a.rgb_blank", 32'(rgb_a), 32'd0);
    end
    chk("lit.a.hs_fall0", 32'(fall0), 32'd657);
    chk("lit.a.hs_fall1", 32'(fall1), 32'd1457);
    chk("lit.a.hs_low_len", 32'(low_a), 32'd96);
    chk("lit.a.de_per_line", 32'(de_cnt_a), 32'd640);
    chk("lit.a.de_first", 32'(de_first_a), 32'd1);
    chk("lit.a.fs_count", 32'(fs_cnt_a), 32'd1);
    chk("lit.b.hs_first", 32'(hs_first_b), 32'd26);
    chk("lit.b.de_first", 32'(de_first_b), 32'd3);
    chk("lit.b.de_per_frame", 32'(de_cnt_b), 32'd120);
    chk("lit.b.vs_len", 32'(vs_cnt_b), 32'd64);
    chk("lit.b.vs_first", 32'(vs_first_b), 32'd259);
    chk("lit.b.fs_count", 32'(fs_cnt_b), 32'd5);

    // Reset in the middle of an hsync pulse on the full-size instance (h=700).
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b1);
    for (int idx = 0; idx < 1500; idx++) run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b0, 1'b1);
      if (k > 0) begin
        chk("lit.rst.a_hsync", 32'(hsync_a), 32'd1);
        chk("lit.rst.a_vsync", 32'(vsync_a), 32'd1);
        chk("lit.rst.a_rgb", 32'(rgb_a), 32'd0);
        chk("lit.rst.a_de", 32'(de_a), 32'd0);
        chk("lit.rst.b_hsync", 32'(hsync_b), 32'd0);
        chk("lit.rst.b_de", 32'(de_b), 32'd0);
      end
    end
    run_cycle(1'b1, 1'b1);
    chk("lit.rel.a_fb_x", 32'(fb_x_a), 32'd0);
    chk("lit.rel.a_fb_y", 32'(fb_y_a), 32'd0);
    chk("lit.rel.a_fs", 32'(frame_start_a), 32'd1);
    chk("lit.rel.b_fs", 32'(frame_start_b), 32'd1);

    // Half-rate pix_ce: same sequence stretched by two clocks per tick.
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b0);
    hs_half_b = -1;
    for (int c = 0; c < 1000; c++) begin
      run_cycle(1'b1, (c % 2) == 0);
      if (hsync_b && hs_half_b < 0) hs_half_b = c;
    end
    chk("lit.half.b_hs_first", 32'(hs_half_b), 32'd51);

    // Random pix_ce with occasional short resets at arbitrary raster positions.
    rst_left = 0;
    for (int c = 0; c < 20000; c++) begin
      if (rst_left == 0 && $urandom_range(0, 1499) == 0) rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin
        rst_left--;
        run_cycle(1'b0, $urandom_range(0, 1) == 1);
      end else begin
        run_cycle(1'b1, $urandom_range(0, 9) < 7);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
